// File: rtl/fifo_arb_pkg.sv
// Shared types and FIFO geometry for the push-side arbiter of simple_fifo.
// The FIFO bench imports the same geometry constants.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    localparam int FIFO_DATA_W = 16;
    localparam int FIFO_DEPTH  = 8;

    // Width of the per-owner beat counter; bounds the largest legal burst.
    localparam int BEAT_W = 4;

endpackage

// File: rtl/fifo_push_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester after last_owner wins.
// Kept generic so pop-side schedulers can reuse it.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_owner,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               any_valid
);

    int cand_s;

    // Scan from the farthest candidate to the nearest; the nearest valid one overwrites the rest.
    always_comb begin
        grant_onehot = '0;
        grant_idx    = '0;
        any_valid    = 1'b0;
        cand_s       = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand_s = (int'(last_owner) + k) % NUM_REQ;
            if (req[cand_s]) begin
                grant_onehot         = '0;
                grant_onehot[cand_s] = 1'b1;
                grant_idx            = IDX_W'(cand_s);
                any_valid            = 1'b1;
            end else begin
                any_valid = any_valid;
            end
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin, burst-limited arbiter sharing the push port of one simple_fifo
// among NUM_REQ valid/ready producers, with zero-latency transfers.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = FIFO_DATA_W,
    parameter int MAX_BURST = 4,
    parameter int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_push,
    output logic [DATA_W-1:0]         fifo_data,
    output logic [IDX_W-1:0]          grant_id,
    output logic                      busy
);

    localparam logic [BEAT_W-1:0] BURST_LIMIT = BEAT_W'(MAX_BURST);
    localparam logic [IDX_W-1:0]  LAST_RESET  = IDX_W'(NUM_REQ - 1);

    arb_state_e          state_r, state_s;
    logic [IDX_W-1:0]    owner_r, owner_s;
    logic [IDX_W-1:0]    last_owner_r, last_owner_s;
    logic [BEAT_W-1:0]   beat_cnt_r, beat_cnt_s;

    logic [NUM_REQ-1:0]  pick_onehot_s;
    logic [IDX_W-1:0]    pick_idx_s;
    logic                pick_any_s;

    logic [NUM_REQ-1:0]  ready_s;
    logic [IDX_W-1:0]    grant_s;
    logic                xfer_s;
    logic [DATA_W-1:0]   data_s;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req          (req_valid),
        .last_owner   (last_owner_r),
        .grant_onehot (pick_onehot_s),
        .grant_idx    (pick_idx_s),
        .any_valid    (pick_any_s)
    );

    // Grant selection: the burst owner is locked in BURST, the picker decides in IDLE.
    always_comb begin
        ready_s = '0;
        grant_s = pick_idx_s;
        case (state_r)
            ST_BURST: begin
                grant_s          = owner_r;
                ready_s[owner_r] = ~fifo_full;
            end
            ST_IDLE: begin
                grant_s = pick_idx_s;
                ready_s = pick_onehot_s & {NUM_REQ{~fifo_full}};
            end
            default: begin
                grant_s = '0;
                ready_s = '0;
            end
        endcase
        xfer_s = |(req_valid & ready_s);
    end

    // Data mux for the granted producer.
    always_comb begin
        data_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_s == IDX_W'(i)) begin
                data_s = req_data[i*DATA_W +: DATA_W];
            end else begin
                data_s = data_s;
            end
        end
    end

    // Next-state logic for the FSM, beat counter and rotation pointer.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        last_owner_s = last_owner_r;
        beat_cnt_s   = beat_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s && pick_any_s) begin
                    if (MAX_BURST == 1) begin
                        last_owner_s = pick_idx_s;
                    end else begin
                        owner_s    = pick_idx_s;
                        beat_cnt_s = BEAT_W'(1);
                        state_s    = ST_BURST;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BURST: begin
                // A dropped valid ends the burst; this cycle is the single bubble.
                if (!req_valid[owner_r]) begin
                    last_owner_s = owner_r;
                    beat_cnt_s   = '0;
                    state_s      = ST_IDLE;
                end else if (xfer_s) begin
                    if ((beat_cnt_r + BEAT_W'(1)) == BURST_LIMIT) begin
                        last_owner_s = owner_r;
                        beat_cnt_s   = '0;
                        state_s      = ST_IDLE;
                    end else begin
                        beat_cnt_s = beat_cnt_r + BEAT_W'(1);
                    end
                end else begin
                    beat_cnt_s = beat_cnt_r;
                end
            end
            default: begin
                state_s      = ST_IDLE;
                owner_s      = '0;
                last_owner_s = LAST_RESET;
                beat_cnt_s   = '0;
            end
        endcase
    end

    // State registers; reset leaves producer 0 with first priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            owner_r      <= '0;
            last_owner_r <= LAST_RESET;
            beat_cnt_r   <= '0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            last_owner_r <= last_owner_s;
            beat_cnt_r   <= beat_cnt_s;
        end
    end

    // Outputs are gated by reset so nothing leaks to the FIFO while it is asserted.
    always_comb begin
        req_ready = reset_n ? ready_s : '0;
        fifo_push = reset_n & xfer_s;
        fifo_data = reset_n ? data_s : '0;
        grant_id  = reset_n ? grant_s : '0;
        busy      = reset_n & ((state_r == ST_BURST) | xfer_s);
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: directed scenarios plus random traffic, all
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_fifo_push_arbiter;
    import fifo_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic            fifo_full [2];
    logic [N-1:0]    rdy [2];
    logic            push [2];
    logic [DW-1:0]   fdata [2];
    logic [IW-1:0]   gid [2];
    logic            busy [2];

    fifo_push_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(4)) dut0 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy[0]), .fifo_full(fifo_full[0]), .fifo_push(push[0]),
        .fifo_data(fdata[0]), .grant_id(gid[0]), .busy(busy[0]));

    fifo_push_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_BURST(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(rdy[1]), .fifo_full(fifo_full[1]), .fifo_push(push[1]),
        .fifo_data(fdata[1]), .grant_id(gid[1]), .busy(busy[1]));

    int mb [2] = '{4, 1};

    // producer side
    logic [DW-1:0] pdata [N];
    logic [N-1:0]  held, want, dut_acc;
    int            acc_cnt [N];
    bit            pop_en, force_full;
    int            fsize [2];

    // model of the arbitration rules
    int            m_burst [2], m_owner [2], m_last [2], m_beats [2];
    logic [N-1:0]  e_ready [2];
    logic          e_push [2];
    int            e_win [2];

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_burst[u] = 0; m_owner[u] = 0; m_last[u] = N - 1; m_beats[u] = 0;
        end
    endtask

    task automatic apply();
        req_valid = held | want;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = pdata[i];
        for (int u = 0; u < 2; u++) fifo_full[u] = (fsize[u] >= FIFO_DEPTH) || force_full;
    endtask

    task automatic model_eval();
        for (int u = 0; u < 2; u++) begin
            e_ready[u] = '0;
            e_win[u]   = -1;
            if (m_burst[u] != 0) begin
                e_win[u] = m_owner[u];
                if (!fifo_full[u]) e_ready[u][m_owner[u]] = 1'b1;
            end else begin
                for (int k = 1; k <= N; k++)
                    if (e_win[u] < 0 && req_valid[(m_last[u] + k) % N]) e_win[u] = (m_last[u] + k) % N;
                if (e_win[u] >= 0 && !fifo_full[u]) e_ready[u][e_win[u]] = 1'b1;
            end
            if (!reset_n) e_ready[u] = '0;
            e_push[u] = |(req_valid & e_ready[u]);
        end
    endtask

    task automatic check_outputs();
        for (int u = 0; u < 2; u++) begin
            if (!reset_n) begin
                chk($sformatf("rst_ready%0d", u), 32'(rdy[u]), 32'd0);
                chk($sformatf("rst_push%0d", u), 32'(push[u]), 32'd0);
                chk($sformatf("rst_busy%0d", u), 32'(busy[u]), 32'd0);
                chk($sformatf("rst_data%0d", u), 32'(fdata[u]), 32'd0);
                chk($sformatf("rst_gid%0d", u), 32'(gid[u]), 32'd0);
            end else begin
                chk($sformatf("ready%0d", u), 32'(rdy[u]), 32'(e_ready[u]));
                chk($sformatf("push%0d", u), 32'(push[u]), 32'(e_push[u]));
                chk($sformatf("busy%0d", u), 32'(busy[u]), 32'(m_burst[u] != 0 || e_push[u]));
                if (m_burst[u] != 0 || e_push[u]) chk($sformatf("gid%0d", u), 32'(gid[u]), 32'(e_win[u]));
                if (e_push[u]) chk($sformatf("data%0d", u), 32'(fdata[u]), 32'(pdata[e_win[u]]));
            end
        end
    endtask

    task automatic model_update();
        for (int u = 0; u < 2; u++) begin
            if (!reset_n) begin
                m_burst[u] = 0; m_owner[u] = 0; m_last[u] = N - 1; m_beats[u] = 0;
            end else begin
                if (pop_en && fsize[u] > 0) fsize[u]--;
                if (e_push[u]) fsize[u]++;
                if (m_burst[u] == 0) begin
                    if (e_push[u]) begin
                        if (mb[u] == 1) m_last[u] = e_win[u];
                        else begin m_burst[u] = 1; m_owner[u] = e_win[u]; m_beats[u] = 1; end
                    end
                end else if (!req_valid[m_owner[u]]) begin
                    m_last[u] = m_owner[u]; m_burst[u] = 0;
                end else if (e_push[u]) begin
                    m_beats[u]++;
                    if (m_beats[u] == mb[u]) begin m_last[u] = m_owner[u]; m_burst[u] = 0; end
                end
            end
        end
        for (int i = 0; i < N; i++)
            if (dut_acc[i]) begin pdata[i] = ~pdata[i]; acc_cnt[i]++; end
        held = req_valid & ~dut_acc;
    endtask

    task automatic settle();
        apply();
        #2;
        model_eval();
        dut_acc = req_valid & rdy[0];
        check_outputs();
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic tick();
        settle();
        finish_cycle();
    endtask

    task automatic wait_acc(input int p, input int n, input string tag);
        int target, b;
        target = acc_cnt[p] + n;
        b = 0;
        while (acc_cnt[p] < target && b < 40) begin tick(); b++; end
        chk(tag, 32'(acc_cnt[p] >= target), 32'd1);
    endtask

    initial begin
        want = '0; held = '0; pop_en = 1'b0; force_full = 1'b0; dut_acc = '0;
        fsize[0] = 0; fsize[1] = 0;
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;
        pdata[0] = 16'h0a00; pdata[1] = 16'h0b11; pdata[2] = 16'h1234; pdata[3] = 16'h0d33;
        model_reset();
        @(negedge clk);

        // reset holds outputs low even with every producer valid
        want = 4'hf;
        repeat (3) tick();
        reset_n = 1'b1;

        // four producers, FIFO filling: 4 beats of p0, 4 of p1, then full
        for (int k = 0; k < 8; k++) begin
            settle();
            chk("s1_push", 32'(push[0]), 32'd1);
            chk("s1_grant", 32'(gid[0]), (k < 4) ? 32'd0 : 32'd1);
            finish_cycle();
        end
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("s1_full_push", 32'(push[0]), 32'd0);
            chk("s1_full_ready", 32'(rdy[0]), 32'd0);
            finish_cycle();
        end

        // p2 alone streams with no bubbles across burst boundaries
        pop_en = 1'b1; held = '0; want = 4'b0100;
        wait_acc(2, 1, "s2_start");
        for (int k = 0; k < 9; k++) begin
            settle();
            chk("s2_push", 32'(push[0]), 32'd1);
            chk("s2_grant", 32'(gid[0]), 32'd2);
            chk("s2_data", 32'(fdata[0]), 32'(pdata[2]));
            finish_cycle();
        end

        // p1 drops valid after two beats while p3 waits
        want = 4'b0010;
        wait_acc(1, 2, "s3_two_beats");
        want = 4'b1000;
        settle();
        chk("s3_bubble_push", 32'(push[0]), 32'd0);
        chk("s3_bubble_busy", 32'(busy[0]), 32'd1);
        finish_cycle();
        settle();
        chk("s3_last_owner", 32'(dut0.last_owner_r), 32'd1);
        chk("s3_grant3", 32'(gid[0]), 32'd3);
        chk("s3_push3", 32'(push[0]), 32'd1);
        finish_cycle();

        // full during a burst of p0 freezes the beat count
        want = 4'b0001;
        wait_acc(0, 2, "s4_two_beats");
        force_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("s4_full_push", 32'(push[0]), 32'd0);
            chk("s4_beat_hold", 32'(dut0.beat_cnt_r), 32'd2);
            chk("s4_full_busy", 32'(busy[0]), 32'd1);
            finish_cycle();
        end
        force_full = 1'b0;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("s4_resume_push", 32'(push[0]), 32'd1);
            chk("s4_resume_grant", 32'(gid[0]), 32'd0);
            finish_cycle();
        end

        // reset pulsed mid-burst, then p0 beats p3
        want = 4'hf;
        repeat (2) tick();
        reset_n = 1'b0;
        settle();
        chk("s5_rst_push", 32'(push[0]), 32'd0);
        chk("s5_rst_ready", 32'(rdy[0]), 32'd0);
        finish_cycle();
        reset_n = 1'b1; held = '0; want = 4'b1001;
        settle();
        chk("s5_grant0", 32'(gid[0]), 32'd0);
        chk("s5_ready0", 32'(rdy[0]), 32'd1);
        finish_cycle();

        // drain, then pure round-robin on the MAX_BURST=1 instance
        want = '0; held = '0;
        repeat (10) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; want = 4'hf;
        for (int k = 0; k < 8; k++) begin
            settle();
            chk("s6_rr_grant", 32'(gid[1]), 32'(k % 4));
            chk("s6_rr_push", 32'(push[1]), 32'd1);
            finish_cycle();
        end

        // random traffic against the model
        for (int c = 0; c < 400; c++) begin
            want = 4'($urandom_range(0, 15));
            pop_en = ($urandom_range(0, 3) != 0);
            force_full = ($urandom_range(0, 15) == 0);
            for (int i = 0; i < N; i++) if (!held[i]) pdata[i] = 16'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_push_arbiter.md
# fifo_push_arbiter

Round-robin, burst-limited arbiter that shares the single push port of one `simple_fifo` (16-bit, depth 8) among `NUM_REQ` producers. Each producer uses a valid/ready handshake. The arbiter drives `push`/`data_in` of the FIFO and honours its `full` flag. It sits directly in front of `simple_fifo`; the pop side is untouched.

## Interface
- `NUM_REQ`, 4: number of producers, 2..8.
- `DATA_W`, 16: data width; must match the FIFO.
- `MAX_BURST`, 4: maximum consecutive transfers one owner may make before rotation, 1..15. A value of 1 gives pure round-robin.
- `IDX_W`, `$clog2(NUM_REQ)`: derived; not overridden.

Ports (reset is `reset_n`, asynchronous, active-low; clock is `clk`):
- `clk`  in  1  clock
- `reset_n`  in  1  async active-low reset
- `req_valid`  in  NUM_REQ  per-producer data valid
- `req_data`  in  NUM_REQ*DATA_W  packed; producer i at bits [i*DATA_W +: DATA_W]
- `req_ready`  out  NUM_REQ  per-producer accept; at most one bit high
- `fifo_full`  in  1  from `simple_fifo.full`
- `fifo_push`  out  1  to `simple_fifo.push`
- `fifo_data`  out  DATA_W  to `simple_fifo.data_in`
- `grant_id`  out  IDX_W  index of the producer currently granted (valid when `busy`)
- `busy`  out  1  high in BURST state or on any transfer cycle

## Operation
- A transfer for producer i occurs on a cycle where `req_valid[i] & req_ready[i]`.
  - `fifo_push` = OR of those terms; `fifo_data` = `req_data` of the granted producer. Both are combinational from registered state plus inputs.
  - Zero latency: the FIFO captures the word on the same rising edge.
- `req_ready[i]` is never high while `fifo_full` is high. Producers must hold `req_valid` and `req_data` stable until accepted.
- Registered state: `state` (IDLE/BURST), `owner` (IDX_W), `last_owner` (IDX_W), `beat_cnt` (4 bits).

IDLE:
- Winner = first i with `req_valid[i]`, searching `last_owner+1`, `last_owner+2`, … modulo `NUM_REQ`.
- `req_ready[winner]` = `~fifo_full`.
- On a transfer:
  - If `MAX_BURST==1`: `last_owner <= winner`; stay in IDLE.
  - Otherwise: `owner <= winner`, `beat_cnt <= 1`, go to BURST.
- With no valid requester or `fifo_full`: no state change.

BURST:
- Only `req_ready[owner]` = `~fifo_full` may be high.
- On a transfer, `beat_cnt++`. If the new count equals `MAX_BURST`: `last_owner <= owner`, go to IDLE.
- If `req_valid[owner]==0`: no transfer that cycle (one bubble); `last_owner <= owner`, go to IDLE.
- If `fifo_full` is high: hold state and `beat_cnt`; the burst resumes when `full` drops.

## Timing
- Reset values: `state`=IDLE, `last_owner`=`NUM_REQ-1` (producer 0 has first priority), `owner`=0, `beat_cnt`=0.
- While `reset_n` is low, `req_ready`, `fifo_push` and `busy` are forced to 0 regardless of inputs; `fifo_data`=0, `grant_id`=0.
- Reset asserted mid-burst:
  - State clears immediately, with no partial push.
  - The first cycle after release arbitrates from producer 0.
- Burst-limit exit is bubble-free: the IDLE cycle that follows arbitrates and can transfer immediately, including to the same producer if it is the only one valid.
- Valid-drop exit costs exactly one cycle without a transfer.
- `fifo_full` is sampled combinationally, with no registered look-ahead. `simple_fifo` must not assert `full` late.
- `beat_cnt` never exceeds `MAX_BURST`; no wrap is possible.

## Structure
- Package `fifo_arb_pkg` holds:
  - the state enum (IDLE, BURST);
  - `FIFO_DATA_W=16` and `FIFO_DEPTH=8`, shared with the `simple_fifo` bench.
- One sub-module `rr_pick`: parameterised combinational round-robin picker.
  - Inputs: request vector, `last_owner`.
  - Outputs: one-hot grant, index, any-valid.
  - Reused by future pop-side schedulers.
- Top level contains the FSM, the counter and the data mux.

## Test plan
- Reset, then all four producers valid continuously, FIFO not full, `MAX_BURST`=4 → producer 0 transfers 4 beats, then producer 1 transfers 4 beats. `fifo_full` rises after 8 pushes, after which `req_ready`=0 and `fifo_push`=0.
- Producer 2 alone holds valid with data 16'h1234, 16'hedcb, … for 10 beats → 10 consecutive pushes with no bubble. `grant_id`=2 throughout; the FIFO pops in the same order.
- Producer 1 in BURST drops valid after 2 beats while producer 3 is valid → one bubble cycle, then producer 3 is granted. `last_owner` becomes 1.
- `fifo_full` forced high during beat 2 of a burst for 3 cycles → no push and `beat_cnt` held at 2. The burst completes with 2 more beats after `full` drops.
- `reset_n` pulsed low mid-burst → `req_ready`/`fifo_push` go low immediately. After release with producers 0 and 3 valid, producer 0 wins.
- `MAX_BURST`=1 with all four producers valid → grant order 0,1,2,3,0,… with one push per cycle and no bubbles.
